// File: rtl/ram_ctrl_pkg.sv
// Shared constants and FSM state encoding for the RAM128 access sequencer.
package ram_ctrl_pkg;

    localparam int unsigned RAM_AW     = 7;
    localparam int unsigned RAM_DW     = 32;
    localparam int unsigned RAM_WE_W   = 4;
    localparam int unsigned RAM_RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

endpackage : ram_ctrl_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last gets the grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_c
);

    // One-hot grant; single request always wins, tie goes to the side != last
    always_comb begin
        gnt_c = 2'b00;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule : rr_arb2

// File: rtl/ram128_arbiter.sv
// Serialises single-word transactions from two requesters onto one RAM128 port.
// Every access (read or write) occupies ISSUE + RD_LAT WAIT cycles, so a delayed
// RAM128 write always commits before the next access starts.
module ram128_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned AW     = RAM_AW,
    parameter int unsigned DW     = RAM_DW,
    parameter int unsigned RD_LAT = RAM_RD_LAT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                r0_req,
    input  logic [RAM_WE_W-1:0] r0_we,
    input  logic [AW-1:0]       r0_addr,
    input  logic [DW-1:0]       r0_wdata,
    output logic                r0_ack,
    output logic [DW-1:0]       r0_rdata,
    input  logic                r1_req,
    input  logic [RAM_WE_W-1:0] r1_we,
    input  logic [AW-1:0]       r1_addr,
    input  logic [DW-1:0]       r1_wdata,
    output logic                r1_ack,
    output logic [DW-1:0]       r1_rdata,
    output logic                ram_en,
    output logic [RAM_WE_W-1:0] ram_we,
    output logic [AW-1:0]       ram_a,
    output logic [DW-1:0]       ram_di,
    input  logic [DW-1:0]       ram_do,
    output logic                busy,
    output logic                gnt_id
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [RAM_WE_W-1:0]   cap_we_q;
    logic                  rr_last_q;

    logic [1:0]            gnt_c;
    logic [RAM_WE_W-1:0]   win_we_c;
    logic                  capture_c;
    logic                  ram_en_d;
    logic [RAM_WE_W-1:0]   ram_we_d;
    logic [1:0]            ack_d;
    logic                  load_rdata_d;
    logic                  busy_d;

    rr_arb2 u_rr_arb2 (
        .req   ({r1_req, r0_req}),
        .last  (rr_last_q),
        .gnt_c (gnt_c)
    );

    assign win_we_c = gnt_c[1] ? r1_we : r0_we;

    // Next-state, latency counter and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_c    = 1'b0;
        ram_en_d     = 1'b0;
        ram_we_d     = '0;
        ack_d        = 2'b00;
        load_rdata_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|gnt_c) begin
                    state_d   = ISSUE;
                    capture_c = 1'b1;
                    ram_en_d  = 1'b1;
                    ram_we_d  = win_we_c;
                end
            end
            ISSUE: begin
                state_d  = WAIT;
                cnt_d    = '0;
                ram_en_d = 1'b1;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    state_d      = ACK;
                    ack_d        = gnt_id ? 2'b10 : 2'b01;
                    load_rdata_d = (cap_we_q == '0);
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    ram_en_d = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register and registered control outputs aligned with the new state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ram_en  <= 1'b0;
            ram_we  <= '0;
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ram_en  <= ram_en_d;
            ram_we  <= ram_we_d;
            r0_ack  <= ack_d[0];
            r1_ack  <= ack_d[1];
            busy    <= busy_d;
        end
    end

    // Capture the winner's request; address/data stay on the RAM port until the next grant
    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt_id   <= 1'b0;
            cap_we_q <= '0;
            ram_a    <= '0;
            ram_di   <= '0;
        end else if (capture_c) begin
            gnt_id   <= gnt_c[1];
            cap_we_q <= win_we_c;
            ram_a    <= gnt_c[1] ? r1_addr  : r0_addr;
            ram_di   <= gnt_c[1] ? r1_wdata : r0_wdata;
        end
    end

    // Read data return and round-robin pointer update on completion
    always_ff @(posedge CLK) begin
        if (RST) begin
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            rr_last_q <= 1'b1;
        end else begin
            if (load_rdata_d) begin
                if (gnt_id) begin
                    r1_rdata <= ram_do;
                end else begin
                    r0_rdata <= ram_do;
                end
            end
            if (state_q == ACK) begin
                rr_last_q <= gnt_id;
            end
        end
    end

endmodule : ram128_arbiter
